// File: rtl/fpr_cdb_arbiter_pkg.sv
// Shared types for the FP common data bus arbiter: bus format, ROB tag width
// and the identity of the unit whose result bus a reserved slot will read.
package fpr_cdb_arbiter_pkg;

   localparam int ROB_WIDTH  = 6;
   localparam int DATA_WIDTH = 32;

   // Request ports, listed in descending grant priority.
   localparam int NUM_REQ        = 4;
   localparam int REQ_FDIV_FSQRT = 0;
   localparam int REQ_FADD       = 1;
   localparam int REQ_FMUL       = 2;
   localparam int REQ_MISC       = 3;

   typedef struct packed {
      logic                  valid;
      logic [ROB_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } cdb_t;

   // SRC_NONE is what an empty slot carries; it never selects a result bus.
   typedef enum logic [2:0] {
      SRC_FDIV  = 3'd0,
      SRC_FSQRT = 3'd1,
      SRC_FADD  = 3'd2,
      SRC_FMUL  = 3'd3,
      SRC_MISC  = 3'd4,
      SRC_NONE  = 3'd7
   } fpr_src_t;

endpackage

// File: rtl/req_if.sv
// Single-beat request handshake between an FP unit and the CDB arbiter.
interface req_if;
   logic valid;
   logic ready;
   modport sink   (input valid, output ready);
   modport source (output valid, input ready);
endinterface

// File: rtl/cdb_slot_shifter.sv
// Reservation shift register for the CDB: slot k holds the result that will
// appear on its unit's result bus k cycles from now. Writes made this cycle
// overlay the current view, so slot 0 reflects a zero-latency write at once.
module cdb_slot_shifter
   import fpr_cdb_arbiter_pkg::*;
#(
   parameter int DEPTH  = 15,
   parameter int NUM_WR = 4,
   parameter int SLOT_W = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_WR-1:0]    wr_en,
   input  logic [SLOT_W-1:0]    wr_slot [NUM_WR],
   input  logic [ROB_WIDTH-1:0] wr_tag  [NUM_WR],
   input  fpr_src_t             wr_src  [NUM_WR],
   output logic [DEPTH:0]       busy,
   output logic                 slot0_valid,
   output logic [ROB_WIDTH-1:0] slot0_tag,
   output fpr_src_t             slot0_src
);

   logic [DEPTH:0]       busy_q;
   logic [DEPTH:0]       busy_eff;
   logic [ROB_WIDTH-1:0] tag_q   [DEPTH+1];
   logic [ROB_WIDTH-1:0] tag_eff [DEPTH+1];
   fpr_src_t             src_q   [DEPTH+1];
   fpr_src_t             src_eff [DEPTH+1];

   // Overlay this cycle's grants on the slots reserved in earlier cycles.
   always_comb begin
      busy_eff = busy_q;
      tag_eff  = tag_q;
      src_eff  = src_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_en[w]) begin
            busy_eff[wr_slot[w]] = 1'b1;
            tag_eff[wr_slot[w]]  = wr_tag[w];
            src_eff[wr_slot[w]]  = wr_src[w];
         end
      end
   end

   // Occupancy moves one slot closer to the bus each cycle; reset drops all.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= {1'b0, busy_eff[DEPTH:1]};
      end
   end

   // Tag and source follow occupancy; they are meaningless where busy is 0.
   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         tag_q[k] <= tag_eff[k+1];
         src_q[k] <= src_eff[k+1];
      end
      tag_q[DEPTH] <= '0;
      src_q[DEPTH] <= SRC_NONE;
   end

   assign busy        = busy_q;
   assign slot0_valid = busy_eff[0];
   assign slot0_tag   = tag_eff[0];
   assign slot0_src   = src_eff[0];

endmodule

// File: rtl/fpr_cdb_arbiter.sv
// FP common data bus arbiter: grants fixed-latency FP units at dispatch time,
// reserving the future CDB slot their result will occupy, then registers the
// matured result onto fpr_cdb. MAX_LAT must cover every LAT_* parameter.
//
// Handshake: a request transfers in any cycle where valid && ready. ready is
// a function of slot occupancy and of the valids of higher-priority sources
// only, never of the source's own valid. While reset is high every ready is 1
// and no grant takes effect.
module fpr_cdb_arbiter
   import fpr_cdb_arbiter_pkg::*;
#(
   parameter int LAT_FDIV  = 11,
   parameter int LAT_FSQRT = 10,
   parameter int LAT_FADD  = 3,
   parameter int LAT_FMUL  = 2,
   parameter int LAT_MISC  = 0,
   parameter int MAX_LAT   = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   req_if.sink                  fdiv_fsqrt_req,
   input  logic                 fpr_cdb_req_is_fsqrt,
   input  logic [ROB_WIDTH-1:0] fdiv_fsqrt_tag,
   input  logic [31:0]          result_fdiv,
   input  logic [31:0]          result_fsqrt,
   req_if.sink                  fadd_req,
   req_if.sink                  fmul_req,
   req_if.sink                  misc_req,
   input  logic [ROB_WIDTH-1:0] fadd_tag,
   input  logic [ROB_WIDTH-1:0] fmul_tag,
   input  logic [ROB_WIDTH-1:0] misc_tag,
   input  logic [31:0]          result_fadd,
   input  logic [31:0]          result_fmul,
   input  logic [31:0]          result_misc,
   output cdb_t                 fpr_cdb
);

   localparam int SLOT_W = $clog2(MAX_LAT + 1);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   grant;
   logic [SLOT_W-1:0]    req_slot [NUM_REQ];
   logic [ROB_WIDTH-1:0] req_tag  [NUM_REQ];
   fpr_src_t             req_src  [NUM_REQ];

   logic [MAX_LAT:0]     busy;
   logic                 slot0_valid;
   logic [ROB_WIDTH-1:0] slot0_tag;
   fpr_src_t             slot0_src;
   logic [31:0]          slot0_data;

   assign req_valid[REQ_FDIV_FSQRT] = fdiv_fsqrt_req.valid;
   assign req_valid[REQ_FADD]       = fadd_req.valid;
   assign req_valid[REQ_FMUL]       = fmul_req.valid;
   assign req_valid[REQ_MISC]       = misc_req.valid;

   // Per-request target slot (effective latency), tag and result source.
   always_comb begin
      req_slot[REQ_FDIV_FSQRT] = fpr_cdb_req_is_fsqrt ? SLOT_W'(LAT_FSQRT) : SLOT_W'(LAT_FDIV);
      req_tag[REQ_FDIV_FSQRT]  = fdiv_fsqrt_tag;
      req_src[REQ_FDIV_FSQRT]  = fpr_cdb_req_is_fsqrt ? SRC_FSQRT : SRC_FDIV;
      req_slot[REQ_FADD]       = SLOT_W'(LAT_FADD);
      req_tag[REQ_FADD]        = fadd_tag;
      req_src[REQ_FADD]        = SRC_FADD;
      req_slot[REQ_FMUL]       = SLOT_W'(LAT_FMUL);
      req_tag[REQ_FMUL]        = fmul_tag;
      req_src[REQ_FMUL]        = SRC_FMUL;
      req_slot[REQ_MISC]       = SLOT_W'(LAT_MISC);
      req_tag[REQ_MISC]        = misc_tag;
      req_src[REQ_MISC]        = SRC_MISC;
   end

   // Ready needs a free target slot and no valid higher-priority source
   // aiming at the same slot; distinct latencies may all be granted at once.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = ~busy[req_slot[i]];
         for (int j = 0; j < i; j++) begin
            if (req_valid[j] && (req_slot[j] == req_slot[i])) begin
               req_ready[i] = 1'b0;
            end
         end
         if (reset) begin
            req_ready[i] = 1'b1;
         end
      end
      grant = req_valid & req_ready & {NUM_REQ{~reset}};
   end

   assign fdiv_fsqrt_req.ready = req_ready[REQ_FDIV_FSQRT];
   assign fadd_req.ready       = req_ready[REQ_FADD];
   assign fmul_req.ready       = req_ready[REQ_FMUL];
   assign misc_req.ready       = req_ready[REQ_MISC];

   cdb_slot_shifter #(
      .DEPTH  (MAX_LAT),
      .NUM_WR (NUM_REQ),
      .SLOT_W (SLOT_W)
   ) u_slots (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (grant),
      .wr_slot     (req_slot),
      .wr_tag      (req_tag),
      .wr_src      (req_src),
      .busy        (busy),
      .slot0_valid (slot0_valid),
      .slot0_tag   (slot0_tag),
      .slot0_src   (slot0_src)
   );

   // Pick the result bus the slot-0 occupant was scheduled on.
   always_comb begin
      slot0_data = '0;
      case (slot0_src)
         SRC_FDIV:  slot0_data = result_fdiv;
         SRC_FSQRT: slot0_data = result_fsqrt;
         SRC_FADD:  slot0_data = result_fadd;
         SRC_FMUL:  slot0_data = result_fmul;
         SRC_MISC:  slot0_data = result_misc;
         default:   slot0_data = '0;
      endcase
   end

   // Register the broadcast; at most one result matures per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         fpr_cdb <= '0;
      end else begin
         fpr_cdb.valid <= slot0_valid;
         fpr_cdb.tag   <= slot0_tag;
         fpr_cdb.data  <= slot0_data;
      end
   end

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Bench for fpr_cdb_arbiter: two instances (default latencies, and fadd/fmul
// sharing latency 3) driven by the same stimulus and checked every cycle
// against a reservation-list model, plus directed literal expectations.
module tb_fpr_cdb_arbiter;
   import fpr_cdb_arbiter_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- stimulus signals ----------------
   logic [3:0]           vld      = '0;
   logic                 is_fsqrt = 1'b0;
   logic [ROB_WIDTH-1:0] tag_fd = '0, tag_fa = '0, tag_fm = '0, tag_mi = '0;
   logic [31:0]          res_fdiv = '0, res_fsqrt = '0, res_fadd = '0, res_fmul = '0, res_misc = '0;
   cdb_t                 cdb0, cdb1;
   logic [3:0]           rdy0, rdy1;

   req_if a_fd(); req_if a_fa(); req_if a_fm(); req_if a_mi();
   req_if b_fd(); req_if b_fa(); req_if b_fm(); req_if b_mi();

   assign a_fd.valid = vld[0]; assign a_fa.valid = vld[1];
   assign a_fm.valid = vld[2]; assign a_mi.valid = vld[3];
   assign b_fd.valid = vld[0]; assign b_fa.valid = vld[1];
   assign b_fm.valid = vld[2]; assign b_mi.valid = vld[3];
   assign rdy0 = {a_mi.ready, a_fm.ready, a_fa.ready, a_fd.ready};
   assign rdy1 = {b_mi.ready, b_fm.ready, b_fa.ready, b_fd.ready};

   fpr_cdb_arbiter dut (
      .clk(clk), .reset(reset),
      .fdiv_fsqrt_req(a_fd), .fpr_cdb_req_is_fsqrt(is_fsqrt), .fdiv_fsqrt_tag(tag_fd),
      .result_fdiv(res_fdiv), .result_fsqrt(res_fsqrt),
      .fadd_req(a_fa), .fmul_req(a_fm), .misc_req(a_mi),
      .fadd_tag(tag_fa), .fmul_tag(tag_fm), .misc_tag(tag_mi),
      .result_fadd(res_fadd), .result_fmul(res_fmul), .result_misc(res_misc),
      .fpr_cdb(cdb0)
   );

   fpr_cdb_arbiter #(.LAT_FMUL(3)) dut_eq (
      .clk(clk), .reset(reset),
      .fdiv_fsqrt_req(b_fd), .fpr_cdb_req_is_fsqrt(is_fsqrt), .fdiv_fsqrt_tag(tag_fd),
      .result_fdiv(res_fdiv), .result_fsqrt(res_fsqrt),
      .fadd_req(b_fa), .fmul_req(b_fm), .misc_req(b_mi),
      .fadd_tag(tag_fa), .fmul_tag(tag_fm), .misc_tag(tag_mi),
      .result_fadd(res_fadd), .result_fmul(res_fmul), .result_misc(res_misc),
      .fpr_cdb(cdb1)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] mk_cdb(input logic [ROB_WIDTH-1:0] t, input logic [31:0] d);
      cdb_t c;
      c.valid = 1'b1;
      c.tag   = t;
      c.data  = d;
      return 64'(c);
   endfunction

   // ---------------- behavioural model ----------------
   // A grant is remembered as "result due on cycle X"; a slot is taken when
   // some earlier grant of the same instance is due on the same cycle.
   // src codes: 0 fdiv, 1 fsqrt, 2 fadd, 3 fmul, 4 misc.
   typedef struct {
      int                   d;
      int                   due;
      logic [ROB_WIDTH-1:0] tag;
      int                   src;
   } pend_t;

   pend_t                pend_q[$];
   bit                   model_on = 1'b0;
   bit                   exp_v    [2];
   logic [ROB_WIDTH-1:0] exp_tag  [2];
   logic [31:0]          exp_data [2];
   int                   n_grant  = 0;

   function automatic int lat_of(input int d, input int s);
      case (s)
         0:       return 11;
         1:       return 10;
         2:       return 3;
         3:       return (d == 1) ? 3 : 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] bus_of(input int s);
      case (s)
         0:       return res_fdiv;
         1:       return res_fsqrt;
         2:       return res_fadd;
         3:       return res_fmul;
         default: return res_misc;
      endcase
   endfunction

   function automatic logic [ROB_WIDTH-1:0] tag_of(input int r);
      case (r)
         0:       return tag_fd;
         1:       return tag_fa;
         2:       return tag_fm;
         default: return tag_mi;
      endcase
   endfunction

   function automatic bit slot_taken(input int d, input int due);
      foreach (pend_q[i]) begin
         if (pend_q[i].d == d && pend_q[i].due == due) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Compare process: checks broadcast and readies mid-cycle, then advances.
   always @(negedge clk) begin
      if (model_on) begin
         for (int d = 0; d < 2; d++) begin
            cdb_t       got;
            logic [3:0] rdy;
            int         lat [4];
            int         src [4];
            bit         want;
            pend_t      p;
            got = (d == 0) ? cdb0 : cdb1;
            rdy = (d == 0) ? rdy0 : rdy1;
            chk($sformatf("cdb%0d.valid c%0d", d, cyc), 64'(got.valid), 64'(exp_v[d]));
            if (exp_v[d]) begin
               chk($sformatf("cdb%0d.tag c%0d", d, cyc), 64'(got.tag), 64'(exp_tag[d]));
               chk($sformatf("cdb%0d.data c%0d", d, cyc), 64'(got.data), 64'(exp_data[d]));
            end
            for (int r = 0; r < 4; r++) begin
               src[r] = (r == 0) ? (is_fsqrt ? 1 : 0) : r + 1;
               lat[r] = lat_of(d, src[r]);
            end
            for (int r = 0; r < 4; r++) begin
               want = 1'b1;
               if (!reset) begin
                  if (slot_taken(d, cyc + lat[r])) want = 1'b0;
                  for (int j = 0; j < r; j++) begin
                     if (vld[j] && lat[j] == lat[r]) want = 1'b0;
                  end
               end
               chk($sformatf("ready%0d[%0d] c%0d", d, r, cyc), 64'(rdy[r]), 64'(want));
               if (!reset && vld[r] && want) begin
                  p.d   = d;
                  p.due = cyc + lat[r];
                  p.tag = tag_of(r);
                  p.src = src[r];
                  pend_q.push_back(p);
                  n_grant++;
               end
            end
            exp_v[d] = 1'b0;
            if (reset) begin
               for (int i = pend_q.size() - 1; i >= 0; i--) begin
                  if (pend_q[i].d == d) pend_q.delete(i);
               end
            end else begin
               for (int i = 0; i < pend_q.size(); i++) begin
                  if (pend_q[i].d == d && pend_q[i].due == cyc) begin
                     exp_v[d]    = 1'b1;
                     exp_tag[d]  = pend_q[i].tag;
                     exp_data[d] = bus_of(pend_q[i].src);
                     pend_q.delete(i);
                     break;
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
      vld       = '0;
      res_fdiv  = $urandom();
      res_fsqrt = $urandom();
      res_fadd  = $urandom();
      res_fmul  = $urandom();
      res_misc  = $urandom();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [ROB_WIDTH-1:0] next_tag;
      next_tag = '0;

      // Reset state: all readies high even with colliding requests.
      step();
      model_on = 1'b1;
      vld = 4'b1111;
      #3;
      chk("reset ready fdiv", 64'(a_fd.ready), 64'd1);
      chk("reset ready eq fmul", 64'(b_fm.ready), 64'd1);
      step(); vld = 4'b1111;
      step();
      reset = 1'b0;
      #3;
      chk("reset cdb valid", 64'(cdb0.valid), 64'd0);

      // Single fdiv: tag 3, result 0x40000000 eleven cycles after grant.
      idle(16);
      step(); vld[0] = 1'b1; is_fsqrt = 1'b0; tag_fd = 6'd3;
      #3; chk("fdiv ready", 64'(a_fd.ready), 64'd1);
      idle(10);
      step(); res_fdiv = 32'h4000_0000;
      #3; chk("fdiv cdb before", 64'(cdb0.valid), 64'd0);
      step(); #3; chk("fdiv cdb", 64'(cdb0), mk_cdb(6'd3, 32'h4000_0000));
      step(); #3; chk("fdiv cdb after", 64'(cdb0.valid), 64'd0);

      // fadd + fmul together; equal-latency instance defers fmul.
      idle(16);
      step(); vld[1] = 1'b1; vld[2] = 1'b1; tag_fa = 6'd10; tag_fm = 6'd11;
      #3;
      chk("pair fadd ready", 64'(a_fa.ready), 64'd1);
      chk("pair fmul ready", 64'(a_fm.ready), 64'd1);
      chk("eq fmul blocked", 64'(b_fm.ready), 64'd0);
      step(); vld[2] = 1'b1; tag_fm = 6'd12;
      #3;
      chk("fmul slot2 taken", 64'(a_fm.ready), 64'd0);
      chk("eq fmul retry", 64'(b_fm.ready), 64'd1);
      step(); res_fmul = 32'h3F80_0000;
      step(); res_fadd = 32'h4040_0000;
      #3; chk("pair fmul cdb", 64'(cdb0), mk_cdb(6'd11, 32'h3F80_0000));
      step(); res_fmul = 32'h4080_0000;
      #3;
      chk("pair fadd cdb", 64'(cdb0), mk_cdb(6'd10, 32'h4040_0000));
      chk("eq fadd cdb", 64'(cdb1), mk_cdb(6'd10, 32'h4040_0000));
      step(); #3; chk("eq fmul cdb", 64'(cdb1), mk_cdb(6'd12, 32'h4080_0000));

      // fdiv then fsqrt: refused one cycle later, accepted two later.
      idle(16);
      step(); vld[0] = 1'b1; is_fsqrt = 1'b0; tag_fd = 6'd20;
      step(); vld[0] = 1'b1; is_fsqrt = 1'b1; tag_fd = 6'd21;
      #3; chk("fsqrt refused", 64'(a_fd.ready), 64'd0);
      step(); vld[0] = 1'b1; is_fsqrt = 1'b1; tag_fd = 6'd21;
      #3; chk("fsqrt accepted", 64'(a_fd.ready), 64'd1);
      step(); is_fsqrt = 1'b0;
      idle(8);
      step(); #3;
      chk("conflict fdiv valid", 64'(cdb0.valid), 64'd1);
      chk("conflict fdiv tag", 64'(cdb0.tag), 64'd20);
      step(); #3;
      chk("conflict fsqrt valid", 64'(cdb0.valid), 64'd1);
      chk("conflict fsqrt tag", 64'(cdb0.tag), 64'd21);

      // Zero-latency misc.
      idle(16);
      step(); vld[3] = 1'b1; tag_mi = 6'd30; res_misc = 32'hBF80_0000;
      #3; chk("misc ready", 64'(a_mi.ready), 64'd1);
      step(); #3; chk("misc cdb", 64'(cdb0), mk_cdb(6'd30, 32'hBF80_0000));

      // Reset with an fdiv in flight, then a fresh fadd.
      idle(16);
      step(); vld[0] = 1'b1; is_fsqrt = 1'b0; tag_fd = 6'd40;
      idle(3);
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      #3; chk("post-reset cdb", 64'(cdb0.valid), 64'd0);
      step(); vld[1] = 1'b1; tag_fa = 6'd41;
      idle(3);
      step(); #3;
      chk("post-reset fadd valid", 64'(cdb0.valid), 64'd1);
      chk("post-reset fadd tag", 64'(cdb0.tag), 64'd41);
      idle(2);
      #3; chk("flushed fdiv", 64'(cdb0.valid), 64'd0);

      // Randomized traffic on both instances.
      idle(16);
      n_grant = 0;
      for (int k = 0; k < 400; k++) begin
         step();
         vld      = 4'($urandom_range(0, 15));
         is_fsqrt = 1'($urandom_range(0, 1));
         tag_fd   = next_tag;
         tag_fa   = next_tag + 6'd1;
         tag_fm   = next_tag + 6'd2;
         tag_mi   = next_tag + 6'd3;
         next_tag = next_tag + 6'd4;
      end
      idle(20);
      chk("random grants >= 100", 64'(n_grant >= 100), 64'd1);
      chk("pending drained", 64'(pend_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
